branch_predictor_btb: RTL and testbench

Parametrised dynamic branch predictor with a tagged branch target buffer. It replaces the static always-taken redirect in the IF stage of the 5-stage pipeline. The IF stage gets a combinational same-cycle prediction (taken, target) for the fetch PC. Branches and jumps resolved in EX train the tables, and the block itself reports mispredictions and the redirect PC used for the IF/ID and ID/EX flush. Two indexing modes are available: bimodal and gshare with global history.

---
 rtl/bp_pkg.sv | 31 +++
 rtl/sat_counter.sv | 36 +++
 rtl/branch_predictor_btb.sv | 143 ++++++++++++++
 tb/tb_branch_predictor_btb.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and constants for the dynamic branch predictor / BTB.
package bp_pkg;

  typedef enum int {
    BP_BIMODAL = 0,
    BP_GSHARE  = 1
  } bp_mode_e;

  localparam int BP_MAX_W   = 64;
  localparam int BP_MAX_CNT = 16;

  // Default 2-bit encodings; wider counters use the helper functions below.
  localparam logic [1:0] WEAK_T  = 2'b10;
  localparam logic [1:0] WEAK_NT = 2'b01;

  typedef struct packed {
    logic                  valid;
    logic [BP_MAX_W-1:0]   tag;
    logic [BP_MAX_W-1:0]   target;
    logic [BP_MAX_CNT-1:0] cnt;
  } bp_entry_t;

  function automatic logic [BP_MAX_CNT-1:0] weak_taken(input int bits);
    return BP_MAX_CNT'(1) << (bits - 1);
  endfunction

  function automatic logic [BP_MAX_CNT-1:0] weak_not_taken(input int bits);
    return weak_taken(bits) - BP_MAX_CNT'(1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up/down counter with a load port; one instance per predictor entry.
module sat_counter
  import bp_pkg::*;
#(
  parameter int               Bits     = 2,
  parameter logic [Bits-1:0]  ResetVal = Bits'(weak_not_taken(Bits))
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_set,
  input  logic [Bits-1:0] i_set_val,
  input  logic            i_inc,
  input  logic            i_dec,
  output logic [Bits-1:0] o_cnt
);

  localparam logic [Bits-1:0] CntMax = '1;

  logic [Bits-1:0] r_cnt;

  // A load always wins over counting so allocation and jump training are exact.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= ResetVal;
    end else if (i_set) begin
      r_cnt <= i_set_val;
    end else if (i_inc && (r_cnt != CntMax)) begin
      r_cnt <= r_cnt + 1'b1;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/branch_predictor_btb.sv
// Dynamic branch predictor with tagged BTB: same-cycle IF lookup, EX-stage
// training, misprediction detection and redirect generation.
module branch_predictor_btb
  import bp_pkg::*;
#(
  parameter int Width    = 32,
  parameter int Entries  = 64,
  parameter int CntBits  = 2,
  parameter int Mode     = 0,
  parameter int HistBits = 6
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [Width-1:0]           pc_i,
  output logic                       pred_taken_o,
  output logic [Width-1:0]           pred_target_o,
  output logic [$clog2(Entries)-1:0] pred_idx_o,
  input  logic                       upd_valid_i,
  input  logic                       upd_jump_i,
  input  logic [Width-1:0]           upd_pc_i,
  input  logic [$clog2(Entries)-1:0] upd_idx_i,
  input  logic                       upd_taken_i,
  input  logic [Width-1:0]           upd_target_i,
  input  logic                       upd_pred_taken_i,
  input  logic [Width-1:0]           upd_pred_target_i,
  output logic                       mispredict_o,
  output logic [Width-1:0]           redirect_pc_o,
  output logic [Width-1:0]           branch_cnt_o,
  output logic [Width-1:0]           miss_cnt_o
);

  localparam int  IdxBits = $clog2(Entries);
  localparam int  TagBits = Width - IdxBits - 2;
  localparam bit  Gshare  = (Mode == int'(BP_GSHARE));

  localparam logic [CntBits-1:0] CntWeakT  = CntBits'(weak_taken(CntBits));
  localparam logic [CntBits-1:0] CntWeakNt = CntBits'(weak_not_taken(CntBits));
  localparam logic [CntBits-1:0] CntMax    = '1;

  logic [Entries-1:0]  r_valid;
  logic [TagBits-1:0]  r_tag    [Entries];
  logic [Width-1:0]    r_target [Entries];
  logic [CntBits-1:0]  w_cnt    [Entries];
  logic [HistBits-1:0] r_ghr;
  logic [Width-1:0]    r_branch_cnt;
  logic [Width-1:0]    r_miss_cnt;

  logic [IdxBits-1:0]  w_pc_idx;
  logic [IdxBits-1:0]  w_lkp_idx;
  logic [TagBits-1:0]  w_pc_tag;
  logic                w_lkp_hit;

  logic [TagBits-1:0]  w_upd_tag;
  logic                w_upd_hit;
  logic                w_cnt_set;
  logic [CntBits-1:0]  w_cnt_set_val;

  // Lookup reads registered state only, so a same-cycle update is not bypassed.
  assign w_pc_idx  = pc_i[IdxBits+1:2];
  assign w_lkp_idx = Gshare ? (w_pc_idx ^ IdxBits'(r_ghr)) : w_pc_idx;
  assign w_pc_tag  = pc_i[Width-1:IdxBits+2];
  assign w_lkp_hit = r_valid[w_lkp_idx] && (r_tag[w_lkp_idx] == w_pc_tag);

  assign pred_idx_o    = w_lkp_idx;
  assign pred_taken_o  = w_lkp_hit && w_cnt[w_lkp_idx][CntBits-1];
  assign pred_target_o = pred_taken_o ? r_target[w_lkp_idx] : (pc_i + Width'(4));

  assign w_upd_tag = upd_pc_i[Width-1:IdxBits+2];
  assign w_upd_hit = r_valid[upd_idx_i] && (r_tag[upd_idx_i] == w_upd_tag);

  // Allocation loads a weak state; a jump on a matching entry pins it to max.
  assign w_cnt_set     = !w_upd_hit || upd_jump_i;
  assign w_cnt_set_val = !w_upd_hit ? (upd_taken_i ? CntWeakT : CntWeakNt) : CntMax;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= '0;
    end else if (upd_valid_i) begin
      r_valid[upd_idx_i] <= 1'b1;
    end
  end

  // Tags and targets are meaningless while the valid bit is clear, so no reset.
  always_ff @(posedge clk_i) begin
    if (upd_valid_i) begin
      r_tag[upd_idx_i] <= w_upd_tag;
      if (upd_taken_i) begin
        r_target[upd_idx_i] <= upd_target_i;
      end
    end
  end

  for (genvar g = 0; g < Entries; g++) begin : g_cnt
    logic w_sel;

    assign w_sel = upd_valid_i && (upd_idx_i == IdxBits'(g));

    sat_counter #(
      .Bits     (CntBits),
      .ResetVal (CntWeakNt)
    ) u_cnt (
      .i_clk     (clk_i),
      .i_rst_n   (rst_ni),
      .i_set     (w_sel && w_cnt_set),
      .i_set_val (w_cnt_set_val),
      .i_inc     (w_sel && upd_taken_i),
      .i_dec     (w_sel && !upd_taken_i),
      .o_cnt     (w_cnt[g])
    );
  end

  // History is trained non-speculatively from resolved conditional branches only.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ghr <= '0;
    end else if (upd_valid_i && !upd_jump_i) begin
      r_ghr <= (r_ghr << 1) | HistBits'(upd_taken_i);
    end
  end

  assign mispredict_o  = upd_valid_i &&
                         ((upd_pred_taken_i != upd_taken_i) ||
                          (upd_taken_i && (upd_pred_target_i != upd_target_i)));
  assign redirect_pc_o = upd_taken_i ? upd_target_i : (upd_pc_i + Width'(4));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_branch_cnt <= '0;
      r_miss_cnt   <= '0;
    end else begin
      if (upd_valid_i && (r_branch_cnt != '1)) begin
        r_branch_cnt <= r_branch_cnt + 1'b1;
      end
      if (mispredict_o && (r_miss_cnt != '1)) begin
        r_miss_cnt <= r_miss_cnt + 1'b1;
      end
    end
  end

  assign branch_cnt_o = r_branch_cnt;
  assign miss_cnt_o   = r_miss_cnt;

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Bench for branch_predictor_btb: directed scenarios plus randomized training
// against an array-based reference model; a second instance covers gshare.
module tb_branch_predictor_btb;

  localparam int Entries = 64;

  logic        clk  = 1'b0;
  logic        rstB = 1'b1;
  logic        rstG = 1'b1;
  logic [31:0] pc, pcG, updPc, updTarget, updPredTarget;
  logic        updValid, updValidG, updJump, updTaken, updPredTaken;
  logic [5:0]  updIdx, updIdxG;

  logic        predTakenB, predTakenG, mispredB, mispredG;
  logic [31:0] predTargetB, predTargetG, redirectB, redirectG;
  logic [31:0] branchCntB, branchCntG, missCntB, missCntG;
  logic [5:0]  predIdxB, predIdxG;

  int checks = 0;
  int errors = 0;

  bit          mValid  [Entries];
  logic [31:0] mTag    [Entries];
  logic [31:0] mTarget [Entries];
  int          mCnt    [Entries];
  int          mBranch;
  int          mMiss;

  always #5 clk = ~clk;

  branch_predictor_btb #(.Width(32), .Entries(Entries), .CntBits(2), .Mode(0), .HistBits(6)) dutB (
    .clk_i(clk), .rst_ni(rstB), .pc_i(pc),
    .pred_taken_o(predTakenB), .pred_target_o(predTargetB), .pred_idx_o(predIdxB),
    .upd_valid_i(updValid), .upd_jump_i(updJump), .upd_pc_i(updPc), .upd_idx_i(updIdx),
    .upd_taken_i(updTaken), .upd_target_i(updTarget),
    .upd_pred_taken_i(updPredTaken), .upd_pred_target_i(updPredTarget),
    .mispredict_o(mispredB), .redirect_pc_o(redirectB),
    .branch_cnt_o(branchCntB), .miss_cnt_o(missCntB)
  );

  branch_predictor_btb #(.Width(32), .Entries(Entries), .CntBits(2), .Mode(1), .HistBits(6)) dutG (
    .clk_i(clk), .rst_ni(rstG), .pc_i(pcG),
    .pred_taken_o(predTakenG), .pred_target_o(predTargetG), .pred_idx_o(predIdxG),
    .upd_valid_i(updValidG), .upd_jump_i(updJump), .upd_pc_i(updPc), .upd_idx_i(updIdxG),
    .upd_taken_i(updTaken), .upd_target_i(updTarget),
    .upd_pred_taken_i(updPredTaken), .upd_pred_target_i(updPredTarget),
    .mispredict_o(mispredG), .redirect_pc_o(redirectG),
    .branch_cnt_o(branchCntG), .miss_cnt_o(missCntG)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic int idxOf(input logic [31:0] a);
    return int'((a >> 2) % Entries);
  endfunction

  function automatic logic [31:0] tagOf(input logic [31:0] a);
    return a >> 8;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < Entries; i++) begin
      mValid[i] = 1'b0;
      mCnt[i]   = 1;
    end
    mBranch = 0;
    mMiss   = 0;
  endtask

  task automatic modelLookup(input logic [31:0] a, output bit taken, output logic [31:0] target);
    int i;
    bit hit;
    i      = idxOf(a);
    hit    = mValid[i] && (mTag[i] == tagOf(a));
    taken  = hit && (mCnt[i] >= 2);
    target = taken ? mTarget[i] : a + 32'd4;
  endtask

  task automatic modelUpdate(input logic [31:0] a, input bit jump, input bit taken, input logic [31:0] target);
    int i;
    i = idxOf(a);
    if (mValid[i] && (mTag[i] == tagOf(a))) begin
      if (jump)       mCnt[i] = 3;
      else if (taken) mCnt[i] = (mCnt[i] == 3) ? 3 : mCnt[i] + 1;
      else            mCnt[i] = (mCnt[i] == 0) ? 0 : mCnt[i] - 1;
    end else begin
      mValid[i] = 1'b1;
      mTag[i]   = tagOf(a);
      mCnt[i]   = taken ? 2 : 1;
    end
    if (taken) mTarget[i] = target;
  endtask

  // One bimodal cycle: lookup and optional resolution, checked before the edge.
  task automatic applyStimulus(input logic [31:0] lkPc, input bit valid, input bit jump,
                               input logic [31:0] uPc, input bit taken, input logic [31:0] target,
                               input bit pTaken, input logic [31:0] pTarget);
    bit          expT;
    logic [31:0] expTgt;
    bit          expMiss;
    @(negedge clk);
    pc = lkPc; updValid = valid; updJump = jump; updPc = uPc; updIdx = 6'(idxOf(uPc));
    updTaken = taken; updTarget = target; updPredTaken = pTaken; updPredTarget = pTarget;
    #1;
    modelLookup(lkPc, expT, expTgt);
    expMiss = valid && ((pTaken != taken) || (taken && (pTarget != target)));
    checkOutput("predTaken", 32'(predTakenB), 32'(expT));
    checkOutput("predTarget", predTargetB, expTgt);
    checkOutput("predIdx", 32'(predIdxB), 32'(idxOf(lkPc)));
    checkOutput("mispredict", 32'(mispredB), 32'(expMiss));
    if (valid) checkOutput("redirect", redirectB, taken ? target : uPc + 32'd4);
    checkOutput("branchCnt", branchCntB, 32'(mBranch));
    checkOutput("missCnt", missCntB, 32'(mMiss));
    @(posedge clk);
    if (valid) begin
      modelUpdate(uPc, jump, taken, target);
      mBranch++;
      if (expMiss) mMiss++;
    end
  endtask

  task automatic resolve(input logic [31:0] a, input bit jump, input bit taken, input logic [31:0] target);
    bit          pT;
    logic [31:0] pTgt;
    modelLookup(a, pT, pTgt);
    applyStimulus(a, 1'b1, jump, a, taken, target, pT, pTgt);
  endtask

  task automatic idleLookup(input logic [31:0] a);
    @(negedge clk);
    pc = a; updValid = 1'b0;
    #1;
  endtask

  initial begin
    logic [31:0] lk, up, tg, pTgt;
    bit          tk, jp, pT;

    pc = 32'h40; pcG = 32'h0; updValid = 1'b0; updValidG = 1'b0; updJump = 1'b0;
    updPc = '0; updIdx = '0; updIdxG = '0; updTaken = 1'b0; updTarget = '0;
    updPredTaken = 1'b0; updPredTarget = '0;
    modelReset();
    #1 rstB = 1'b0; rstG = 1'b0;
    #2;
    checkOutput("rstPredTaken", 32'(predTakenB), 32'd0);
    checkOutput("rstPredTarget", predTargetB, 32'h44);
    checkOutput("rstPredIdx", 32'(predIdxB), 32'h10);
    checkOutput("rstBranchCnt", branchCntB, 32'd0);
    checkOutput("rstMissCnt", missCntB, 32'd0);
    checkOutput("rstMispredict", 32'(mispredB), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rstB = 1'b1; rstG = 1'b1;

    for (int k = 0; k < 3; k++) resolve(32'h100, 1'b0, 1'b1, 32'h80);
    idleLookup(32'h100);
    checkOutput("trainTaken", 32'(predTakenB), 32'd1);
    checkOutput("trainTarget", predTargetB, 32'h80);
    checkOutput("trainMissCnt", missCntB, 32'd1);
    checkOutput("trainBranchCnt", branchCntB, 32'd3);

    resolve(32'h200, 1'b0, 1'b1, 32'h300);
    idleLookup(32'h100);
    checkOutput("aliasOldTaken", 32'(predTakenB), 32'd0);
    checkOutput("aliasOldTarget", predTargetB, 32'h104);
    idleLookup(32'h200);
    checkOutput("aliasNewTaken", 32'(predTakenB), 32'd1);
    checkOutput("aliasNewTarget", predTargetB, 32'h300);

    resolve(32'h200, 1'b0, 1'b1, 32'h300);
    resolve(32'h200, 1'b0, 1'b1, 32'h300);
    for (int k = 0; k < 4; k++) begin
      resolve(32'h200, 1'b0, 1'b0, 32'h300);
      idleLookup(32'h200);
      checkOutput($sformatf("satNotTaken%0d", k), 32'(predTakenB), (k == 0) ? 32'd1 : 32'd0);
    end
    resolve(32'h200, 1'b0, 1'b1, 32'h300);
    idleLookup(32'h200);
    checkOutput("noWrap", 32'(predTakenB), 32'd0);

    applyStimulus(32'h20, 1'b1, 1'b1, 32'h20, 1'b1, 32'h400, 1'b0, 32'h24);
    idleLookup(32'h20);
    checkOutput("jalTaken", 32'(predTakenB), 32'd1);
    checkOutput("jalTarget", predTargetB, 32'h400);

    for (int n = 0; n < 300; n++) begin
      lk = (32'($urandom_range(0, 7)) << 8) | (32'($urandom_range(0, 3)) << 2);
      up = (32'($urandom_range(0, 7)) << 8) | (32'($urandom_range(0, 3)) << 2);
      tg = $urandom & 32'hFFFF_FFFC;
      jp = ($urandom_range(0, 7) == 0);
      tk = jp ? 1'b1 : 1'($urandom_range(0, 1));
      modelLookup(up, pT, pTgt);
      if ($urandom_range(0, 3) == 0) begin
        pT   = 1'($urandom_range(0, 1));
        pTgt = $urandom & 32'hFFFF_FFFC;
      end
      applyStimulus(lk, ($urandom_range(0, 4) != 0), jp, up, tk, tg, pT, pTgt);
    end

    // Gshare: one taken conditional branch makes the history 0b000001.
    @(negedge clk);
    updValid = 1'b0;
    updValidG = 1'b1; updIdxG = 6'd0; updPc = 32'h500; updJump = 1'b0;
    updTaken = 1'b1; updTarget = 32'h900; updPredTaken = 1'b0; updPredTarget = 32'h504;
    @(posedge clk);
    @(negedge clk);
    updValidG = 1'b0; pcG = 32'h100;
    #1;
    checkOutput("gshareIdx", 32'(predIdxG), 32'h01);
    checkOutput("gshareBranchCnt", branchCntG, 32'd1);

    @(negedge clk);
    updValidG = 1'b1; updIdxG = 6'd1; updPc = 32'h104; updTaken = 1'b1; updTarget = 32'h900;
    #2 rstG = 1'b0;
    @(posedge clk);
    #1 updValidG = 1'b0;
    rstG = 1'b1;
    @(negedge clk);
    pcG = 32'h104;
    #1;
    checkOutput("rstCancelTaken", 32'(predTakenG), 32'd0);
    checkOutput("rstGhrIdx", 32'(predIdxG), 32'h01);
    checkOutput("rstGBranchCnt", branchCntG, 32'd0);
    pcG = 32'h500;
    #1;
    checkOutput("rstClearedEntry", 32'(predTakenG), 32'd0);
    checkOutput("rstClearedTarget", predTargetG, 32'h504);
    checkOutput("rstGhrIdx0", 32'(predIdxG), 32'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
